// File: rtl/muldiv_if.sv
// Start/busy/done handshake and HI/LO readback bundle for the iterative multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one step per clock over WIDTH cycles.
// Optional MADD/MSUB accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     add_s, trial_s, diff_s;
  logic [2*WIDTH-1:0] step_s, prod_res_s;
  logic [WIDTH-1:0]   quot_s, rem_s, res_hi_s, res_lo_s, abs_a_s, abs_b_s;
  logic               sa_s, sb_s, is_div_s;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return (op[2:1] != 2'b11);
`endif
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // Operand magnitudes and signs for the op being offered at the accept edge
  always_comb begin
    sa_s     = op_signed(bus.op) && bus.a[WIDTH-1];
    sb_s     = op_signed(bus.op) && bus.b[WIDTH-1];
    abs_a_s  = sa_s ? -bus.a : bus.a;
    abs_b_s  = sb_s ? -bus.b : bus.b;
    is_div_s = op_is_div(bus.op);
  end

  // One iteration: multiply shifts the multiplier out of prod_q's low half while
  // summing into the high half; divide shifts the dividend into a restoring remainder.
  always_comb begin
    add_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    trial_s = prod_q[2*WIDTH-1:WIDTH-1];
    diff_s  = trial_s - {1'b0, opnd_q};
    if (op_is_div(op_q)) begin
      if (!diff_s[WIDTH]) begin
        step_s = {diff_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {trial_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      end
    end else if (prod_q[0]) begin
      step_s = {add_s, prod_q[WIDTH-1:1]};
    end else begin
      step_s = {1'b0, prod_q[2*WIDTH-1:1]};
    end
  end

  // Sign-corrected final result from the last step; HI/LO cannot change mid-op,
  // so the live HI/LO equal the accumulator sampled at acceptance.
  always_comb begin
    prod_res_s = neg_q ? -step_s : step_s;
    quot_s     = neg_q ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
    rem_s      = rem_neg_q ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
    res_hi_s   = hi_q;
    res_lo_s   = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: {res_hi_s, res_lo_s} = prod_res_s;
      OP_DIV, OP_DIVU: begin
        if (opnd_q == {WIDTH{1'b0}}) begin
          res_hi_s = a_q;
          res_lo_s = {WIDTH{1'b1}};
        end else begin
          res_hi_s = rem_s;
          res_lo_s = quot_s;
        end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD: {res_hi_s, res_lo_s} = {hi_q, lo_q} + prod_res_s;
      OP_MSUB: {res_hi_s, res_lo_s} = {hi_q, lo_q} - prod_res_s;
`endif
      default: {res_hi_s, res_lo_s} = {hi_q, lo_q};
    endcase
  end

  // Next-state and register updates for the IDLE/RUN controller
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush && op_legal(bus.op)) begin
          case (bus.op)
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: begin
              state_d   = RUN;
              busy_d    = 1'b1;
              cnt_d     = {CW{1'b0}};
              op_d      = bus.op;
              a_d       = bus.a;
              neg_d     = sa_s ^ sb_s;
              rem_neg_d = sa_s;
              prod_d    = {{WIDTH{1'b0}}, is_div_s ? abs_a_s : abs_b_s};
              opnd_d    = is_div_s ? abs_b_s : abs_a_s;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          prod_d = step_s;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hi_d    = res_hi_s;
            lo_d    = res_lo_s;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      op_q      <= 3'b000;
      prod_q    <= {(2*WIDTH){1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      a_q       <= {WIDTH{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] model_hilo;
  logic [63:0] pend;

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              q, r;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'(sa * sb);
    case (op)
      3'd0: return p;
      3'd1: return 64'(ua * ub);
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, hilo[31:0]};
      3'd5: return {hilo[63:32], a};
      3'd6: return hilo + p;
      3'd7: return hilo - p;
      default: return hilo;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Caller sits on a negedge; start is held for exactly one rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    pend      = ref_model(op, a, b, model_hilo);
    @(negedge clk);
    bus.start = 1'b0;
    if (op == 3'd4 || op == 3'd5) begin
      model_hilo = pend;
      check("mt_busy", {63'd0, bus.busy}, 64'd0);
      check("mt_hilo", {bus.hi, bus.lo}, model_hilo);
    end else begin
      check("accept_busy", {63'd0, bus.busy}, 64'd1);
      check("accept_done", {63'd0, bus.done}, 64'd0);
    end
  endtask

  task automatic wait_done(input string tag, input bit inject);
    int cycles;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 64) begin
      cycles++;
      if (inject && cycles == 5) begin
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 32'hDEADBEEF;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(cycles), 64'd32);
    check({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    check({tag, "_hilo"}, {bus.hi, bus.lo}, pend);
    model_hilo = pend;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    issue(op, a, b);
    if (op != 3'd4 && op != 3'd5) wait_done("op", inject);
  endtask

  task automatic count_done(input string tag);
    int pulses;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check(tag, 64'(pulses), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          nops;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0; bus.flush = 1'b0;
    rst = 1'b1;
    model_hilo = 64'd0;
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a multiply
    run_op(3'd4, 32'h00001234, 32'd0, 1'b0);
    issue(3'd0, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    model_hilo = 64'd0;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done("midrst_no_done");

    // Directed arithmetic vectors, the DIV issued in the MULTU done cycle
    run_op(3'd0, 32'hFFFFFFFD, 32'h00000005, 1'b0);
    check("mult_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b1);
    check("div_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd3, 32'h00001234, 32'h00000000, 1'b0);
    check("divu_zero", {bus.hi, bus.lo}, 64'h00001234_FFFFFFFF);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);

    // Flush mid-divide
    run_op(3'd4, 32'h0000ABCD, 32'd0, 1'b0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_done", {63'd0, bus.done}, 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, model_hilo);
    check("flush_hi", {32'd0, bus.hi}, 64'h0000ABCD);
    count_done("flush_no_done");

    // Flush and start on the same edge: nothing accepted
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.op = 3'd4; bus.a = 32'h55555555;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    check("flushstart_busy", {63'd0, bus.busy}, 64'd0);
    check("flushstart_hilo", {bus.hi, bus.lo}, model_hilo);

    // Accumulate ops
    run_op(3'd4, 32'h00000000, 32'd0, 1'b0);
    run_op(3'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MULDIV_MADD_EN
    run_op(3'd6, 32'd1, 32'd1, 1'b0);
    check("madd_const", {bus.hi, bus.lo}, 64'h00000001_00000000);
    run_op(3'd7, 32'd3, 32'hFFFFFFFE, 1'b0);
    nops = 8;
`else
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'd1; bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("illegal_busy", {63'd0, bus.busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("illegal_done", {63'd0, bus.done}, 64'd0);
    check("illegal_hilo", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFF);
    nops = 6;
`endif

    // Randomized ops, back to back
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, nops - 1));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 200));
      run_op(rop, ra, rb, i[0]);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
